sub86_mem_arb: RTL and testbench

//  Round-robin arbiter sharing the single-port sub86 data RAM between NREQ bus masters
//  (core data port via hold wrapper, DMA loader, debug port).

---
 rtl/sub86_pkg.sv | 27 ++
 rtl/sub86_mem_arb_if.sv | 38 +++
 rtl/sub86_rr_pick.sv | 29 ++
 rtl/sub86_mem_arb.sv | 112 +++++++++++
 tb/tb_sub86_mem_arb.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/sub86_pkg.sv
// Shared constants for the sub86 data-RAM arbiter.
//  - Arbiter FSM encodings
//  - RAM size codes carried on BEN/MBEN
//  - Idle bus values driven to the RAM when no access executes
//  - Read-return pipeline entry type
package sub86_pkg;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_OWNED  = 2'd1;
    localparam logic [1:0] ARB_LOCKED = 2'd2;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_DWORD = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b11;

    localparam logic       IDLE_MWEN = 1'b1;
    localparam logic [1:0] IDLE_MBEN = SZ_BYTE;

    // Owner index width in the read pipe; covers up to 8 masters.
    localparam int IDXW = 3;

    typedef struct packed {
        logic            vld;
        logic [IDXW-1:0] idx;
    } rd_ent_t;

endpackage

// File: rtl/sub86_mem_arb_if.sv
// Bus bundle between the sub86 masters / RAM macro and the arbiter.
//  Master side: REQ, LOCK, WEN_I, A_I, Q_I, BEN_I (packed per master) -> GNT, RDV, RD
//  RAM side:    MA, MQ, MWEN, MBEN out to the macro, MD back from it
//  modport slave  : the arbiter
//  modport master : the masters plus the RAM macro (everything around the arbiter)
interface sub86_mem_arb_if #(
    parameter int NREQ = 3,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    import sub86_pkg::*;

    logic [NREQ-1:0]    REQ;
    logic [NREQ-1:0]    LOCK;
    logic [NREQ-1:0]    WEN_I;
    logic [NREQ*AW-1:0] A_I;
    logic [NREQ*DW-1:0] Q_I;
    logic [NREQ*2-1:0]  BEN_I;
    logic [NREQ-1:0]    GNT;
    logic [NREQ-1:0]    RDV;
    logic [DW-1:0]      RD;
    logic [AW-1:0]      MA;
    logic [DW-1:0]      MQ;
    logic               MWEN;
    logic [1:0]         MBEN;
    logic [DW-1:0]      MD;

    modport slave (
        input  REQ, LOCK, WEN_I, A_I, Q_I, BEN_I, MD,
        output GNT, RDV, RD, MA, MQ, MWEN, MBEN
    );

    modport master (
        output REQ, LOCK, WEN_I, A_I, Q_I, BEN_I, MD,
        input  GNT, RDV, RD, MA, MQ, MWEN, MBEN
    );

endinterface

// File: rtl/sub86_rr_pick.sv
// Combinational round-robin picker.
//  req : request vector
//  ptr : index where the search starts (wraps modulo NREQ)
//  oh  : one-hot winner, idx : winner index, any : at least one request
module sub86_rr_pick #(
    parameter  int NREQ = 3,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] oh,
    output logic [PW-1:0]   idx,
    output logic            any
);

    always_comb begin
        oh  = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req[(int'(ptr) + k) % NREQ]) begin
                any                         = 1'b1;
                oh[(int'(ptr) + k) % NREQ]  = 1'b1;
                idx                         = PW'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/sub86_mem_arb.sv
// Round-robin arbiter sharing the single-port sub86 data RAM between NREQ masters.
//  CLK, RST : clock, synchronous active-high reset
//  bus      : slave side of sub86_mem_arb_if (master requests in, grants/read
//             return out, RAM A/Q/WEN/BEN pins out, RAM read data in)
// GNT is registered; an access executes in any cycle with GNT[i] & REQ[i] and
// the RAM pins are muxed combinationally from that master. LOCK keeps the
// grant on the owner for up to MAXLOCK consecutive accesses.
module sub86_mem_arb import sub86_pkg::*; #(
    parameter int NREQ    = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RD_LAT  = 1,
    parameter int MAXLOCK = 16
) (
    input  logic          CLK,
    input  logic          RST,
    sub86_mem_arb_if.slave bus
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(MAXLOCK + 1);

    logic [1:0]              state_q, state_d;
    logic [NREQ-1:0]         gnt_q, gnt_d;
    logic [PW-1:0]           own_q, own_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    rd_ent_t [RD_LAT-1:0]    pipe_q, pipe_d;

    logic                    access;
    logic                    hold;
    logic [NREQ-1:0]         pick_oh;
    logic [PW-1:0]           pick_idx;
    logic                    pick_any;
    logic [NREQ-1:0]         rdv;

    // Accesses are suppressed during the reset cycle so the RAM never sees a
    // write while the arbiter state is being cleared.
    assign access = !RST && |(gnt_q & bus.REQ);

    // Search for the next owner starts just past the master that accessed
    // this cycle; a sole requester therefore wraps around to itself.
    always_comb begin
        ptr_d = ptr_q;
        if (access) begin
            ptr_d = (own_q == PW'(NREQ - 1)) ? '0 : own_q + PW'(1);
        end
    end

    sub86_rr_pick #(.NREQ(NREQ)) u_pick (
        .req (bus.REQ),
        .ptr (ptr_d),
        .oh  (pick_oh),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Ownership is kept only on a locked access that has not used up its
    // MAXLOCK budget; every other case (unlocked access, owner idle for a
    // cycle, budget exhausted) falls back to normal arbitration.
    always_comb begin
        hold = access && bus.LOCK[own_q] &&
               (state_q != ARB_LOCKED || cnt_q < CW'(MAXLOCK - 1));
        gnt_d   = hold ? gnt_q : pick_oh;
        own_d   = hold ? own_q : pick_idx;
        cnt_d   = hold ? cnt_q + CW'(1) : '0;
        state_d = hold ? ARB_LOCKED : (pick_any ? ARB_OWNED : ARB_IDLE);
    end

    // Read return: reads enter at the head with their owner, RDV fires from the tail.
    always_comb begin
        pipe_d[0].vld = access && bus.WEN_I[own_q];
        pipe_d[0].idx = IDXW'(own_q);
        for (int k = 1; k < RD_LAT; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
    end

    always_comb begin
        rdv = '0;
        for (int i = 0; i < NREQ; i++) begin
            rdv[i] = !RST && pipe_q[RD_LAT-1].vld && (pipe_q[RD_LAT-1].idx == IDXW'(i));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            own_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            pipe_q  <= pipe_d;
        end
    end

    assign bus.GNT  = gnt_q;
    assign bus.RDV  = rdv;
    assign bus.RD   = bus.MD;
    assign bus.MA   = access ? bus.A_I[int'(own_q)*AW +: AW] : '0;
    assign bus.MQ   = access ? bus.Q_I[int'(own_q)*DW +: DW] : '0;
    assign bus.MWEN = access ? bus.WEN_I[own_q] : IDLE_MWEN;
    assign bus.MBEN = access ? bus.BEN_I[int'(own_q)*2 +: 2] : IDLE_MBEN;

endmodule

// File: tb/tb_sub86_mem_arb.sv
// Directed bench for sub86_mem_arb: u0 (RD_LAT=1) carries the arbitration,
// read, write and lock sequences; u1 (RD_LAT=2) the mid-read reset case.
// Each bus has a small RAM model preloaded on reset with base+address.
module tb_sub86_mem_arb;
    import sub86_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sub86_mem_arb_if #(.NREQ(3), .AW(32), .DW(32)) b0 ();
    sub86_mem_arb_if #(.NREQ(3), .AW(32), .DW(32)) b1 ();

    sub86_mem_arb #(.NREQ(3), .AW(32), .DW(32), .RD_LAT(1), .MAXLOCK(16)) u0 (
        .CLK(clk), .RST(rst), .bus(b0.slave));
    sub86_mem_arb #(.NREQ(3), .AW(32), .DW(32), .RD_LAT(2), .MAXLOCK(16)) u1 (
        .CLK(clk), .RST(rst), .bus(b1.slave));

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    logic [31:0] md0, md1a, md1b;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 256; k++) mem0[k] <= 32'hA000_0000 + k;
        end else if (!b0.MWEN) begin
            mem0[b0.MA[7:0]] <= b0.MQ;
        end
        md0 <= mem0[b0.MA[7:0]];
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 256; k++) mem1[k] <= 32'hB000_0000 + k;
        end else if (!b1.MWEN) begin
            mem1[b1.MA[7:0]] <= b1.MQ;
        end
        md1a <= mem1[b1.MA[7:0]];
        md1b <= md1a;
    end

    assign b0.MD = md0;
    assign b1.MD = md1b;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input int i, input logic req, input logic lock, input logic wen,
                        input logic [31:0] a, input logic [31:0] q, input logic [1:0] ben);
        b0.REQ[i]           = req;
        b0.LOCK[i]          = lock;
        b0.WEN_I[i]         = wen;
        b0.A_I[i*32 +: 32]  = a;
        b0.Q_I[i*32 +: 32]  = q;
        b0.BEN_I[i*2 +: 2]  = ben;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        b0.REQ = 3'b111; b0.LOCK = '0; b0.WEN_I = '1; b0.A_I = '0; b0.Q_I = '0;
        b0.BEN_I = {3{SZ_WORD}};
        b1.REQ = '0;     b1.LOCK = '0; b1.WEN_I = '1; b1.A_I = '0; b1.Q_I = '0;
        b1.BEN_I = {3{SZ_WORD}};

        // 1: reset with everyone requesting, then 0,1,2,0 rotation
        tick(); #1;
        chk("rst_gnt",  32'(b0.GNT), 32'h0);
        chk("rst_rdv",  32'(b0.RDV), 32'h0);
        chk("rst_mwen", 32'(b0.MWEN), 32'h1);
        rst = 1'b0;
        tick(); #1; chk("rr_gnt0", 32'(b0.GNT), 32'h1);
        tick(); #1; chk("rr_gnt1", 32'(b0.GNT), 32'h2);
        chk("rr_rdv0", 32'(b0.RDV), 32'h1);
        chk("rr_rd0",  b0.RD, 32'hA000_0000);
        tick(); #1; chk("rr_gnt2", 32'(b0.GNT), 32'h4);
        tick(); b0.REQ = '0; #1; chk("rr_gnt3", 32'(b0.GNT), 32'h1);

        // 2: master 1 streams four reads at 0x10..0x13
        tick(); drv0(1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, SZ_WORD); #1;
        chk("idle_gnt", 32'(b0.GNT), 32'h0);
        chk("idle_ma",  b0.MA, 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k < 4) b0.A_I[32 +: 32] = 32'h10 + 32'(k);
            else       b0.REQ[1] = 1'b0;
            #1;
            if (k < 4) begin
                chk("b2b_gnt", 32'(b0.GNT), 32'h2);
                chk("b2b_ma",  b0.MA, 32'h10 + 32'(k));
            end
            if (k > 0) begin
                chk("b2b_rdv", 32'(b0.RDV), 32'h2);
                chk("b2b_rd",  b0.RD, 32'hA000_0010 + 32'(k - 1));
            end
        end

        // 3: master 0 writes 0x40, master 2 reads it back
        tick(); drv0(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'hDEAD_BEEF, SZ_DWORD); #1;
        chk("wr_pre_gnt",  32'(b0.GNT), 32'h0);
        chk("wr_pre_mwen", 32'(b0.MWEN), 32'h1);
        tick(); drv0(2, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, SZ_WORD); #1;
        chk("wr_gnt",  32'(b0.GNT), 32'h1);
        chk("wr_mwen", 32'(b0.MWEN), 32'h0);
        chk("wr_ma",   b0.MA, 32'h40);
        chk("wr_mq",   b0.MQ, 32'hDEAD_BEEF);
        chk("wr_mben", 32'(b0.MBEN), 32'(SZ_DWORD));
        tick(); b0.REQ[0] = 1'b0; b0.WEN_I[0] = 1'b1; #1;
        chk("rb_gnt",       32'(b0.GNT), 32'h4);
        chk("wr_post_mwen", 32'(b0.MWEN), 32'h1);
        chk("rb_ma",        b0.MA, 32'h40);
        tick(); b0.REQ[2] = 1'b0; #1;
        chk("rb_rdv", 32'(b0.RDV), 32'h4);
        chk("rb_rd",  b0.RD, 32'hDEAD_BEEF);

        // 4: master 1 locks for 3 accesses while 0 and 2 wait
        tick(); drv0(1, 1'b1, 1'b1, 1'b1, 32'h20, 32'h0, SZ_WORD); #1;
        chk("lk_pre_gnt", 32'(b0.GNT), 32'h0);
        tick(); b0.REQ = 3'b111; #1; chk("lk_gnt_a", 32'(b0.GNT), 32'h2);
        tick(); #1;                  chk("lk_gnt_b", 32'(b0.GNT), 32'h2);
        tick(); b0.LOCK[1] = 1'b0; #1; chk("lk_gnt_c", 32'(b0.GNT), 32'h2);
        tick(); b0.REQ[1] = 1'b0; #1;  chk("lk_next2", 32'(b0.GNT), 32'h4);
        tick(); b0.REQ = '0; #1;       chk("lk_next0", 32'(b0.GNT), 32'h1);

        // 5: master 0 LOCK stuck high, master 1 waiting -> forced release
        tick(); b0.REQ = 3'b011; b0.LOCK = 3'b001; #1;
        chk("ml_pre_gnt", 32'(b0.GNT), 32'h0);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick(); #1;
            if (b0.GNT == 3'b001) n++;
            else break;
        end
        chk("ml_count", 32'(n), 32'd16);
        chk("ml_gnt1",  32'(b0.GNT), 32'h2);
        b0.REQ = '0; b0.LOCK = '0;

        // 6: RD_LAT=2, reset one cycle after a master-2 read issues
        tick(); b1.REQ = 3'b100; b1.A_I[64 +: 32] = 32'h5; #1;
        tick(); #1;
        chk("l2_gnt", 32'(b1.GNT), 32'h4);
        chk("l2_ma",  b1.MA, 32'h5);
        tick(); rst = 1'b1; b1.WEN_I[2] = 1'b0; #1;
        chk("l2_rst_mwen", 32'(b1.MWEN), 32'h1);
        chk("l2_rst_rdv",  32'(b1.RDV), 32'h0);
        tick(); rst = 1'b0; b1.REQ = '0; b1.WEN_I = '1; #1;
        chk("l2_post_gnt",  32'(b1.GNT), 32'h0);
        chk("l2_post_rdv",  32'(b1.RDV), 32'h0);
        chk("l2_post_mwen", 32'(b1.MWEN), 32'h1);
        chk("l2_post_mben", 32'(b1.MBEN), 32'(IDLE_MBEN));
        chk("l2_post_ma",   b1.MA, 32'h0);
        chk("l2_post_mq",   b1.MQ, 32'h0);
        tick(); #1;
        chk("l2_late_rdv",  32'(b1.RDV), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
